cpu_bus_if: RTL and testbench

//  CPU-side bus master interface. Sits downstream of bus_slave_mux and consumes its mRdData/mRdy_.

---
 rtl/cpu_bus_if_pkg.sv | 19 +
 rtl/cpu_bus_if_timer.sv | 33 +++
 rtl/cpu_bus_if.sv | 148 ++++++++++++++
 tb/tb_cpu_bus_if.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_if_pkg.sv
// Shared constants, state encoding and timeout counter width for the CPU bus master interface.
// The BUS_TIMEOUT_EN build option uses BUS_TIMEOUT_W.
package cpu_bus_if_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int unsigned BUS_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } bus_if_state_e;

endpackage

// File: rtl/cpu_bus_if_timer.sv
// ACCESS-phase timeout counter, built only when BUS_TIMEOUT_EN is defined.
// The count is the 1-based number of the current ACCESS cycle.
`ifdef BUS_TIMEOUT_EN
module cpu_bus_if_timer
    import cpu_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [BUS_TIMEOUT_W-1:0] LIMIT = BUS_TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [BUS_TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= BUS_TIMEOUT_W'(1);
        end else if (enable) begin
            cnt <= cnt + BUS_TIMEOUT_W'(1);
        end
    end

    assign expire = enable && (cnt == LIMIT);

endmodule
`endif

// File: rtl/cpu_bus_if.sv
// CPU-side bus master: turns one pipeline request into request/grant/access/ready on the bus.
// Optional ACCESS timeout with busErr pulse when BUS_TIMEOUT_EN is defined.
module cpu_bus_if
    import cpu_bus_if_pkg::*;
#(
    parameter int unsigned WORD_DATA_W = 32,
    parameter int unsigned WORD_ADDR_W = 30
`ifdef BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wrData,
    output logic [WORD_DATA_W-1:0] rdData,
    output logic                   busy,
    output logic                   busReq_,
    input  logic                   busGrnt_,
    output logic [WORD_ADDR_W-1:0] busAddr,
    output logic                   busAs_,
    output logic                   busRw,
    output logic [WORD_DATA_W-1:0] busWrData,
    input  logic [WORD_DATA_W-1:0] busRdData,
    input  logic                   busRdy_
`ifdef BUS_TIMEOUT_EN
  , output logic                   busErr
`endif
);

    bus_if_state_e state, state_next;

    logic                   rdy;
    logic                   timeout;
    logic                   accept;
    logic                   done;
    logic [WORD_DATA_W-1:0] rd_done;
    logic [WORD_DATA_W-1:0] rd_buf;

    assign rdy    = (busRdy_ == ENABLE_);
    assign accept = (state == IDLE) && (as_ == ENABLE_) && !flush;
    assign done   = (state == ACCESS) && (rdy || timeout);
    // A timeout or a write completes with zero, so STALL replays the same value.
    assign rd_done = (rdy && busRw == READ) ? busRdData : '0;

`ifdef BUS_TIMEOUT_EN
    cpu_bus_if_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == REQ),
        .enable (state == ACCESS),
        .expire (timeout)
    );

    assign busErr = timeout && !rdy;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rdData     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    busy       = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (busGrnt_ == ENABLE_) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (done) begin
                    rdData     = rd_done;
                    state_next = stall ? STALL : IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            STALL: begin
                rdData = rd_buf;
                if (!stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busReq_   <= DISABLE_;
            busAs_    <= DISABLE_;
            busRw     <= READ;
            busAddr   <= '0;
            busWrData <= '0;
            rd_buf    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busAddr   <= addr;
                        busRw     <= rw;
                        busWrData <= wrData;
                        busReq_   <= ENABLE_;
                    end
                end
                REQ: begin
                    if (flush) begin
                        busReq_ <= DISABLE_;
                    end else if (busGrnt_ == ENABLE_) begin
                        busAs_ <= ENABLE_;
                    end
                end
                ACCESS: begin
                    busAs_ <= DISABLE_;
                    if (done) begin
                        busReq_ <= DISABLE_;
                        rd_buf  <= rd_done;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_if.sv
// Directed bench for cpu_bus_if: per-cycle vector table plus reset, wait and timeout sequences.
// Define BUS_TIMEOUT_EN to build the timeout variant with TIMEOUT_CYCLES=16.
module tb_cpu_bus_if;
    import cpu_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        as_;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        busy;
    logic        busReq_;
    logic        busGrnt_;
    logic [29:0] busAddr;
    logic        busAs_;
    logic        busRw;
    logic [31:0] busWrData;
    logic [31:0] busRdData;
    logic        busRdy_;
`ifdef BUS_TIMEOUT_EN
    logic        busErr;
`endif

    int checks   = 0;
    int failures = 0;

    cpu_bus_if #(
        .WORD_DATA_W(32),
        .WORD_ADDR_W(30)
`ifdef BUS_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .as_       (as_),
        .rw        (rw),
        .addr      (addr),
        .wrData    (wrData),
        .rdData    (rdData),
        .busy      (busy),
        .busReq_   (busReq_),
        .busGrnt_  (busGrnt_),
        .busAddr   (busAddr),
        .busAs_    (busAs_),
        .busRw     (busRw),
        .busWrData (busWrData),
        .busRdData (busRdData),
        .busRdy_   (busRdy_)
`ifdef BUS_TIMEOUT_EN
      , .busErr    (busErr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        as_n;
        logic        fl;
        logic        st;
        logic        rw;
        logic [29:0] a;
        logic [31:0] wd;
        logic        gnt_n;
        logic        rdy_n;
        logic [31:0] rb;
        logic        e_busy;
        logic        e_req_n;
        logic        e_as_n;
        logic [31:0] e_rd;
        logic        e_rw;
        logic [29:0] e_addr;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic as_n, input logic fl, input logic st, input logic r,
                                input logic [29:0] a, input logic [31:0] wd, input logic gnt_n,
                                input logic rdy_n, input logic [31:0] rb, input logic e_busy,
                                input logic e_req_n, input logic e_as_n, input logic [31:0] e_rd,
                                input logic e_rw, input logic [29:0] e_addr, input logic [31:0] e_wd);
        vec_t v;
        v.as_n = as_n; v.fl = fl; v.st = st; v.rw = r; v.a = a; v.wd = wd;
        v.gnt_n = gnt_n; v.rdy_n = rdy_n; v.rb = rb;
        v.e_busy = e_busy; v.e_req_n = e_req_n; v.e_as_n = e_as_n; v.e_rd = e_rd;
        v.e_rw = e_rw; v.e_addr = e_addr; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic as_n, input logic r, input logic [29:0] a,
                         input logic [31:0] wd, input logic gnt_n, input logic rdy_n,
                         input logic [31:0] rb);
        as_ = as_n; rw = r; addr = a; wrData = wd;
        busGrnt_ = gnt_n; busRdy_ = rdy_n; busRdData = rb;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"},      {31'd0, busy},      32'd0);
        chk({tag, " busReq_"},   {31'd0, busReq_},   32'd1);
        chk({tag, " busAs_"},    {31'd0, busAs_},    32'd1);
        chk({tag, " busRw"},     {31'd0, busRw},     {31'd0, READ});
        chk({tag, " busAddr"},   {2'd0, busAddr},    32'd0);
        chk({tag, " busWrData"}, busWrData,          32'd0);
        chk({tag, " rdData"},    rdData,             32'd0);
`ifdef BUS_TIMEOUT_EN
        chk({tag, " busErr"},    {31'd0, busErr},    32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // as,fl,st,rw,addr,wd,gnt_n,rdy_n,rdbus | busy,req_n,as_n,rdData,busRw,busAddr,busWrData
        // 1: read, immediate grant, ready in the busAs_ cycle
        tbl[0]  = mk(0,0,0,1,30'h0AA,32'h0,1,1,32'h0,          1,1,1,32'h0,       1,30'h000,32'h0);
        tbl[1]  = mk(0,0,0,1,30'h0AA,32'h0,0,1,32'h0,          1,0,1,32'h0,       1,30'h0AA,32'h0);
        tbl[2]  = mk(0,0,0,1,30'h0AA,32'h0,0,0,32'h1234_5678,  0,0,0,32'h1234_5678,1,30'h0AA,32'h0);
        tbl[3]  = mk(1,0,0,1,30'h0AA,32'h0,1,1,32'h0,          0,1,1,32'h0,       1,30'h0AA,32'h0);
        // 2: write, grant after three REQ cycles, ready on third ACCESS cycle
        tbl[4]  = mk(0,0,0,0,30'h100,32'hCAFE_F00D,1,1,32'h0,  1,1,1,32'h0,       1,30'h0AA,32'h0);
        tbl[5]  = mk(0,0,0,0,30'h100,32'hCAFE_F00D,1,1,32'h0,  1,0,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[6]  = mk(0,0,0,0,30'h100,32'hCAFE_F00D,1,1,32'h0,  1,0,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[7]  = mk(0,0,0,0,30'h100,32'hCAFE_F00D,1,1,32'h0,  1,0,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[8]  = mk(0,0,0,0,30'h100,32'hCAFE_F00D,0,1,32'h0,  1,0,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[9]  = mk(0,0,0,0,30'h000,32'h0,1,1,32'h0,          1,0,0,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[10] = mk(0,0,0,0,30'h000,32'h0,1,1,32'h0,          1,0,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[11] = mk(0,0,0,0,30'h000,32'h0,1,0,32'hDEAD_BEEF,  0,0,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[12] = mk(1,0,0,0,30'h000,32'h0,1,1,32'h0,          0,1,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        // 3: flush in REQ wins over a simultaneous grant; flush blocks acceptance in IDLE
        tbl[13] = mk(0,0,0,1,30'h3FF,32'h0,1,1,32'h0,          1,1,1,32'h0,       0,30'h100,32'hCAFE_F00D);
        tbl[14] = mk(0,1,0,1,30'h3FF,32'h0,0,1,32'h0,          1,0,1,32'h0,       1,30'h3FF,32'h0);
        tbl[15] = mk(0,1,0,1,30'h3FF,32'h0,1,1,32'h0,          0,1,1,32'h0,       1,30'h3FF,32'h0);
        tbl[16] = mk(1,0,0,1,30'h3FF,32'h0,1,1,32'h0,          0,1,1,32'h0,       1,30'h3FF,32'h0);
        // 4: read completing under stall held four cycles
        tbl[17] = mk(0,0,0,1,30'h055,32'h0,0,1,32'h0,          1,1,1,32'h0,       1,30'h3FF,32'h0);
        tbl[18] = mk(0,0,0,1,30'h055,32'h0,0,1,32'h0,          1,0,1,32'h0,       1,30'h055,32'h0);
        tbl[19] = mk(0,0,1,1,30'h055,32'h0,1,0,32'hA5A5_5A5A,  0,0,0,32'hA5A5_5A5A,1,30'h055,32'h0);
        tbl[20] = mk(0,0,1,1,30'h055,32'h0,0,1,32'h0,          0,1,1,32'hA5A5_5A5A,1,30'h055,32'h0);
        tbl[21] = mk(0,0,1,1,30'h055,32'h0,0,1,32'h0,          0,1,1,32'hA5A5_5A5A,1,30'h055,32'h0);
        tbl[22] = mk(0,0,1,1,30'h055,32'h0,0,1,32'h0,          0,1,1,32'hA5A5_5A5A,1,30'h055,32'h0);
        tbl[23] = mk(0,0,0,1,30'h055,32'h0,0,1,32'h0,          0,1,1,32'hA5A5_5A5A,1,30'h055,32'h0);
        tbl[24] = mk(1,0,0,1,30'h055,32'h0,0,1,32'h0,          0,1,1,32'h0,       1,30'h055,32'h0);

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 30'h0, 32'h0, 1, 1, 32'h0);
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");

        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].as_n, tbl[i].rw, tbl[i].a, tbl[i].wd, tbl[i].gnt_n, tbl[i].rdy_n, tbl[i].rb);
            flush = tbl[i].fl;
            stall = tbl[i].st;
            #1;
            chk($sformatf("row%0d busy", i),      {31'd0, busy},    {31'd0, tbl[i].e_busy});
            chk($sformatf("row%0d busReq_", i),   {31'd0, busReq_}, {31'd0, tbl[i].e_req_n});
            chk($sformatf("row%0d busAs_", i),    {31'd0, busAs_},  {31'd0, tbl[i].e_as_n});
            chk($sformatf("row%0d rdData", i),    rdData,           tbl[i].e_rd);
            chk($sformatf("row%0d busRw", i),     {31'd0, busRw},   {31'd0, tbl[i].e_rw});
            chk($sformatf("row%0d busAddr", i),   {2'd0, busAddr},  {2'd0, tbl[i].e_addr});
            chk($sformatf("row%0d busWrData", i), busWrData,        tbl[i].e_wd);
            @(negedge clk);
        end
        flush = 1'b0; stall = 1'b0;

        // 5: reset taken on the second ACCESS cycle
        drive(0, 1, 30'h02A, 32'h0000_0011, 1, 1, 32'h0);
        #1 chk("rst_seq accept busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        drive(0, 1, 30'h02A, 32'h0000_0011, 0, 1, 32'h0);
        #1 chk("rst_seq req busReq_", {31'd0, busReq_}, 32'd0);
        @(negedge clk);
        drive(0, 1, 30'h02A, 32'h0000_0011, 1, 1, 32'h0);
        #1 chk("rst_seq access busAs_", {31'd0, busAs_}, 32'd0);
        chk("rst_seq access busy", {31'd0, busy}, 32'd1);
        chk("rst_seq access busAddr", {2'd0, busAddr}, 32'h0000_002A);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_seq access2 busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        drive(1, 1, 30'h0, 32'h0, 1, 1, 32'h0);
        #1 chk_reset_outputs("rst_in_access");
        reset = 1'b0;
        @(negedge clk);
        drive(0, WRITE, 30'h007, 32'h0000_0055, 0, 1, 32'h0);
        #1 chk("post_rst idle busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1 chk("post_rst req busReq_", {31'd0, busReq_}, 32'd0);
        chk("post_rst req busAddr", {2'd0, busAddr}, 32'h0000_0007);
        chk("post_rst req busWrData", busWrData, 32'h0000_0055);
        @(negedge clk);
        drive(0, WRITE, 30'h007, 32'h0000_0055, 1, 0, 32'h1111_1111);
        #1 chk("post_rst access busy", {31'd0, busy}, 32'd0);
        chk("post_rst access rdData", rdData, 32'd0);
        chk("post_rst access busRw", {31'd0, busRw}, {31'd0, WRITE});
        @(negedge clk);
        drive(1, 1, 30'h0, 32'h0, 1, 1, 32'h0);
        #1 chk("post_rst idle busReq_", {31'd0, busReq_}, 32'd1);
        @(negedge clk);

`ifdef BUS_TIMEOUT_EN
        // 6: unmapped read times out on ACCESS cycle 16
        drive(0, READ, 30'h3FFF_FFF, 32'h0, 0, 1, 32'h0);
        @(negedge clk);
        #1 chk("tmo req busReq_", {31'd0, busReq_}, 32'd0);
        @(negedge clk);
        for (int c = 1; c <= 15; c++) begin
            busRdData = 32'hFFFF_0000;
            #1;
            chk($sformatf("tmo cyc%0d busy", c),   {31'd0, busy},   32'd1);
            chk($sformatf("tmo cyc%0d busErr", c), {31'd0, busErr}, 32'd0);
            @(negedge clk);
        end
        #1 chk("tmo cyc16 busErr", {31'd0, busErr}, 32'd1);
        chk("tmo cyc16 busy", {31'd0, busy}, 32'd0);
        chk("tmo cyc16 rdData", rdData, 32'd0);
        @(negedge clk);
        drive(1, READ, 30'h0, 32'h0, 1, 1, 32'h0);
        #1 chk("tmo after busReq_", {31'd0, busReq_}, 32'd1);
        chk("tmo after busErr", {31'd0, busErr}, 32'd0);
        @(negedge clk);

        // ready coinciding with the terminal count completes normally
        drive(0, READ, 30'h0123, 32'h0, 0, 1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        for (int c = 1; c <= 15; c++) begin
            #1 chk($sformatf("tmo_rdy cyc%0d busy", c), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        busRdy_ = 1'b0; busRdData = 32'h0BAD_F00D;
        #1 chk("tmo_rdy cyc16 busErr", {31'd0, busErr}, 32'd0);
        chk("tmo_rdy cyc16 rdData", rdData, 32'h0BAD_F00D);
        chk("tmo_rdy cyc16 busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        drive(1, READ, 30'h0, 32'h0, 1, 1, 32'h0);
        @(negedge clk);
`else
        // unmapped read waits without bound, then completes when ready finally arrives
        drive(0, READ, 30'h3FFF_FFF, 32'h0, 0, 1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            #1 chk($sformatf("wait cyc%0d busy", c), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        busRdy_ = 1'b0; busRdData = 32'h7777_8888;
        #1 chk("wait done busy", {31'd0, busy}, 32'd0);
        chk("wait done rdData", rdData, 32'h7777_8888);
        @(negedge clk);
        drive(1, READ, 30'h0, 32'h0, 1, 1, 32'h0);
        #1 chk("wait idle busReq_", {31'd0, busReq_}, 32'd1);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
